// File: rtl/aes_dec_core.sv
// Iterative AES-128 inverse cipher: forward key expansion to the round-10 key,
// then one inverse round per advancing cycle while the key schedule walks back.
module aes_dec_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    input  logic         step_en,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        ADD0  = 3'd2,
        ROUND = 3'd3,
        FINAL = 3'd4
    } state_t;

    // Tables are written byte 0 first, so entry x lives at index ~x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[~x];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[~x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? {1'b1, x[7:1] ^ 7'h0d} : {1'b0, x[7:1]};
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = rk[31:0] ^ rk[63:32];
        n2 = rk[63:32] ^ rk[95:64];
        n1 = rk[95:64] ^ rk[127:96];
        n0 = rk[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

    // Byte index is {column, row}; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        logic [3:0]   dst;
        logic [3:0]   src;
        o = 128'h0;
        for (int i = 0; i < 16; i++) begin
            dst = 4'(i);
            src = {dst[3:2] - dst[1:0], dst[1:0]};
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*int'(src) -: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int j = 0; j < 4; j++) begin
            a[j]  = col[31 - 8*j -: 8];
            x2[j] = xtime(a[j]);
            x4[j] = xtime(x2[j]);
            x8[j] = xtime(x4[j]);
            m9[j] = x8[j] ^ a[j];
            mb[j] = x8[j] ^ x2[j] ^ a[j];
            md[j] = x8[j] ^ x4[j] ^ a[j];
            me[j] = x8[j] ^ x4[j] ^ x2[j];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    state_t       state_r, state_s;
    logic [127:0] st_r, st_s;
    logic [127:0] rk_r, rk_s;
    logic [3:0]   rnd_r, rnd_s;
    logic [7:0]   rcon_r, rcon_s;
    logic         busy_r, busy_s;
    logic         done_r, done_s;
    logic [127:0] pt_r, pt_s;
    logic [127:0] inv_st_s;

    // Next-state and datapath: nothing moves while busy and step_en is low.
    always_comb begin
        state_s  = state_r;
        st_s     = st_r;
        rk_s     = rk_r;
        rnd_s    = rnd_r;
        rcon_s   = rcon_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        pt_s     = pt_r;
        inv_st_s = inv_shift_sub(st_r);
        if (state_r == IDLE) begin
            if (start) begin
                rk_s    = key;
                st_s    = ciphertext;
                rnd_s   = 4'd1;
                rcon_s  = 8'h01;
                pt_s    = 128'h0;
                busy_s  = 1'b1;
                state_s = KEXP;
            end else begin
                busy_s  = 1'b0;
            end
        end else if (step_en) begin
            case (state_r)
                KEXP: begin
                    rk_s = fwd_key(rk_r, rcon_r);
                    if (rnd_r == 4'd10) begin
                        rcon_s  = 8'h36;
                        state_s = ADD0;
                    end else begin
                        rcon_s  = xtime(rcon_r);
                        rnd_s   = rnd_r + 4'd1;
                    end
                end
                ADD0: begin
                    st_s    = st_r ^ rk_r;
                    rk_s    = inv_key(rk_r, rcon_r);
                    rcon_s  = inv_xtime(rcon_r);
                    rnd_s   = 4'd9;
                    state_s = ROUND;
                end
                ROUND: begin
                    st_s   = inv_mix(inv_st_s ^ rk_r);
                    rk_s   = inv_key(rk_r, rcon_r);
                    rcon_s = inv_xtime(rcon_r);
                    rnd_s  = rnd_r - 4'd1;
                    if (rnd_r == 4'd1) begin
                        state_s = FINAL;
                    end else begin
                        state_s = ROUND;
                    end
                end
                FINAL: begin
                    pt_s    = inv_st_s ^ rk_r;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
                default: begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            st_r    <= 128'h0;
            rk_r    <= 128'h0;
            rnd_r   <= 4'd0;
            rcon_r  <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pt_r    <= 128'h0;
        end else begin
            state_r <= state_s;
            st_r    <= st_s;
            rk_r    <= rk_s;
            rnd_r   <= rnd_s;
            rcon_r  <= rcon_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pt_r    <= pt_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign plaintext = pt_r;

endmodule

// File: tb/tb_aes_dec_core.sv
// Self-checking bench for aes_dec_core: known-answer vectors, stalls, start/reset
// handling and random round trips against a behavioural AES-128 encryptor.
module tb_aes_dec_core;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         step_en;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;

    int           n_cmp = 0;
    int           n_err = 0;
    int           done_cnt = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sb_m [0:255];
    logic [15:0]  lfsr = 16'hace1;

    aes_dec_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .ciphertext (ciphertext),
        .step_en    (step_en),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt_m(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_m(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt_m(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul_m(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb_m[a] = s;
        end
    endtask

    function automatic logic [127:0] kexp_m(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {rk[23:0], rk[31:24]};
        t  = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]} ^ {rc, 24'h000000};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] round_m(input logic [127:0] s, input logic [127:0] rk, input bit last);
        logic [127:0] t, m;
        logic [7:0]   a0, a1, a2, a3;
        int           r, c;
        for (int i = 0; i < 16; i++) begin
            r = i % 4;
            c = i / 4;
            t[127 - 8*i -: 8] = sb_m[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
        end
        m = t;
        if (!last) begin
            for (int k = 0; k < 4; k++) begin
                a0 = t[127 - 32*k -: 8];
                a1 = t[119 - 32*k -: 8];
                a2 = t[111 - 32*k -: 8];
                a3 = t[103 - 32*k -: 8];
                m[127 - 32*k -: 8] = xt_m(a0) ^ xt_m(a1) ^ a1 ^ a2 ^ a3;
                m[119 - 32*k -: 8] = a0 ^ xt_m(a1) ^ xt_m(a2) ^ a2 ^ a3;
                m[111 - 32*k -: 8] = a0 ^ a1 ^ xt_m(a2) ^ xt_m(a3) ^ a3;
                m[103 - 32*k -: 8] = xt_m(a0) ^ a0 ^ a1 ^ a2 ^ xt_m(a3);
            end
        end
        return m ^ rk;
    endfunction

    function automatic logic [127:0] enc_m(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] rk, s;
        logic [7:0]   rc;
        rk = k; s = p ^ k; rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = kexp_m(rk, rc);
            rc = xt_m(rc);
            s  = round_m(s, rk, r == 10);
        end
        return s;
    endfunction

    // Scoreboard: every done pops the oldest expected plaintext.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) check("spurious_done", 128'(done), 128'd0);
            else check("plaintext", plaintext, exp_q.pop_front());
        end
    end

    // Issue one block from a falling edge; lat counts edges from acceptance to done.
    task automatic run_block(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                             input bit stall, input int inj_a, input int inj_b,
                             output int lat, output int bcnt, output int stalls);
        key = k; ciphertext = c; start = 1'b1; step_en = 1'b1;
        exp_q.push_back(p);
        lat = -1; bcnt = 0; stalls = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 0) check("pt_cleared", plaintext, 128'h0);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (busy === 1'b1) bcnt++;
            start = (i == inj_a) || (i == inj_b);
            if (start) begin
                key = ~k; ciphertext = ~c;
            end
            if (stall) begin
                step_en = lfsr[0] | lfsr[1];
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
            if (busy === 1'b1 && !step_en) stalls++;
            @(negedge clk);
        end
        start = 1'b0;
        step_en = 1'b1;
    endtask

    initial begin
        int lat, bc, st, d0;
        logic [127:0] k, p, c;
        build_sbox();
        rst = 1'b1; start = 1'b0; step_en = 1'b1; key = 128'h0; ciphertext = 128'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_pt", plaintext, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        run_block(K1, C1, P1, 1'b0, -1, -1, lat, bc, st);
        check("c1_latency", 128'(lat), 128'd21);
        check("c1_busy_cycles", 128'(bc), 128'd21);
        repeat (3) @(negedge clk);
        check("pt_hold", plaintext, P1);

        run_block(KB, CB, PB, 1'b0, -1, -1, lat, bc, st);
        check("b_latency", 128'(lat), 128'd21);

        run_block(K1, C1, P1, 1'b1, -1, -1, lat, bc, st);
        check("stall_latency", 128'(lat), 128'(21 + st));
        check("stall_busy_cycles", 128'(bc), 128'(21 + st));

        run_block(K1, C1, P1, 1'b0, 5, 15, lat, bc, st);
        check("ignored_start_latency", 128'(lat), 128'd21);

        run_block(KB, CB, PB, 1'b0, -1, -1, lat, bc, st);
        run_block(K1, C1, P1, 1'b0, -1, -1, lat, bc, st);
        check("b2b_latency", 128'(lat), 128'd21);

        key = K1; ciphertext = C1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_pt", plaintext, 128'h0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("abort_no_done", 128'(done_cnt), 128'(d0));

        rst = 1'b1; start = 1'b1; key = KB; ciphertext = CB;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 128'(busy), 128'd0);
        repeat (30) @(negedge clk);
        check("rst_start_no_done", 128'(done_cnt), 128'(d0));

        for (int n = 0; n < 200; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = enc_m(k, p);
            run_block(k, c, p, 1'b0, -1, -1, lat, bc, st);
            check("rt_latency", 128'(lat), 128'd21);
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
